pattern_lock_controller: RTL

Sequencing and configuration controller for the pattern checker path. It consumes the single-cycle action pulses produced by the debouncer and rising-edge-to-pulse chain. It collects a multi-digit code, compares it against a stored, user-reprogrammable pattern, and drives the RGB LED with entry, pass, fail and lockout indications. It sits where `pattern_checker` sits in the top level, fed by `pulse_data_out_sig` and `code_in`.

---
 rtl/pattern_lock_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pattern_lock_controller.sv
// pattern_lock_controller: multi-digit code entry, compare, reprogram and lockout FSM driving the RGB LED (lockout gated by PATTERN_LOCK_LOCKOUT_EN).
// action_in at cycle N updates state/idx/LEDs at edge N+1; no backpressure, action_in is dropped in PASS/FAIL/LOCKOUT.
module pattern_lock_controller #(
  parameter int PATTERN_LEN    = 4,
  parameter int MAX_FAILS      = 3,
  parameter int RESULT_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       action_in,
  input  logic       program_in,
  input  logic [3:0] code_in,
  output logic       led_r_out,
  output logic       led_g_out,
  output logic       led_b_out
);

  localparam int IDX_W   = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam int TMR_MAX = (RESULT_CYCLES > LOCKOUT_CYCLES) ? RESULT_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PATTERN_LEN - 1);
  localparam logic [3:0]       FAIL_SAT    = 4'(MAX_FAILS);
  localparam logic [TMR_W-1:0] RESULT_LOAD = TMR_W'(RESULT_CYCLES - 1);
`ifdef PATTERN_LOCK_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {ENTER, PASS, FAIL, LOCKOUT, PROGRAM} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             mismatch, mismatch_nxt;
  logic [3:0]       fail_cnt, fail_cnt_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [3:0]       pattern [PATTERN_LEN];
  logic             pat_we;
  logic             digit_diff;

  // LED bits are {r, g, b}
  function automatic logic [2:0] led_decode(input state_t s, input logic [IDX_W-1:0] i);
    logic [2:0] leds;
    leds = 3'b000;
    case (s)
      ENTER:   leds = {2'b00, (i != '0)};
      PASS:    leds = 3'b010;
      FAIL:    leds = 3'b100;
      LOCKOUT: leds = 3'b101;
      PROGRAM: leds = 3'b011;
      default: leds = 3'b000;
    endcase
    return leds;
  endfunction

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    mismatch_nxt = mismatch;
    fail_cnt_nxt = fail_cnt;
    timer_nxt    = timer;
    pat_we       = 1'b0;
    digit_diff   = (code_in != pattern[idx]);
    case (state)
      ENTER: begin
        if (action_in) begin
          if (idx == LAST_IDX) begin
            idx_nxt      = '0;
            mismatch_nxt = 1'b0;
            timer_nxt    = RESULT_LOAD;
            if (!mismatch && !digit_diff) begin
              state_nxt    = PASS;
              fail_cnt_nxt = 4'd0;
            end else begin
              state_nxt    = FAIL;
              fail_cnt_nxt = (fail_cnt == FAIL_SAT) ? fail_cnt : fail_cnt + 4'd1;
            end
          end else begin
            mismatch_nxt = mismatch | digit_diff;
            idx_nxt      = idx + 1'b1;
          end
        end
      end
      PASS: begin
        if (timer == '0) state_nxt = program_in ? PROGRAM : ENTER;
        else             timer_nxt = timer - 1'b1;
      end
      FAIL: begin
        if (timer == '0) begin
`ifdef PATTERN_LOCK_LOCKOUT_EN
          if (fail_cnt == FAIL_SAT) begin
            state_nxt = LOCKOUT;
            timer_nxt = LOCKOUT_LOAD;
          end else begin
            state_nxt = ENTER;
          end
`else
          state_nxt = ENTER;
`endif
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_nxt    = ENTER;
          fail_cnt_nxt = 4'd0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      PROGRAM: begin
        if (action_in) begin
          pat_we = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = ENTER;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = ENTER;
    endcase
  end

  // Reset also restores the default pattern, discarding any partial reprogramming
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ENTER;
      idx      <= '0;
      mismatch <= 1'b0;
      fail_cnt <= 4'd0;
      timer    <= '0;
      for (int i = 0; i < PATTERN_LEN; i++) pattern[i] <= 4'(i);
      {led_r_out, led_g_out, led_b_out} <= 3'b000;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mismatch <= mismatch_nxt;
      fail_cnt <= fail_cnt_nxt;
      timer    <= timer_nxt;
      if (pat_we) pattern[idx] <= code_in;
      {led_r_out, led_g_out, led_b_out} <= led_decode(state_nxt, idx_nxt);
    end
  end

endmodule
